// File: rtl/gpu_core_pkg.sv
// Shared encodings for the GPU core control path (scheduler, fetcher, decoder, LSU).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_core_pkg;

    // Scheduler state, broadcast to every per-core unit as core_state.
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    // Per-thread LSU state.
    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    // Fetcher state meaning the instruction word is available.
    localparam logic [2:0] FETCHER_FETCHED = 3'b010;

endpackage

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE; owns the PC.
// Latency: 6 cycles per instruction plus fetch wait plus memory wait cycles.
// Backpressure: holds in FETCH until the fetcher reports FETCHED, holds in WAIT while any active LSU is busy.
//
// Ports: clk/reset (sync, active-high); start, thread_count (latched at start);
//        fetcher_state, decoded_ret, lsu_state (packed 2b/lane), next_pc (packed per lane);
//        core_state, current_pc, done, divergence_error (sticky), busy_cycles (saturating).
module core_scheduler
    import gpu_core_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int CYCLE_COUNT_BITS      = 16
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]                 thread_count,
    input  logic [2:0]                                         fetcher_state,
    input  logic                                               decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                                         core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic                                               done,
    output logic                                               divergence_error,
    output logic [CYCLE_COUNT_BITS-1:0]                        busy_cycles
);

    localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int PW   = PROGRAM_MEM_ADDR_BITS;
    localparam int CW   = CYCLE_COUNT_BITS;

    core_state_e     state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic            done_q, done_d;
    logic            div_q, div_d;
    logic [CW-1:0]   busy_q, busy_d;
    logic [TC_W-1:0] tc_q, tc_d;

    logic [THREADS_PER_BLOCK-1:0] active;
    logic [THREADS_PER_BLOCK-1:0] lane_busy;
    logic [THREADS_PER_BLOCK-1:0] lane_diverge;

    // Lane g participates only when it is below the latched thread count.
    // Lanes in IDLE or DONE are not waiting on memory.
    // Lane 0 always matches itself, so no special case is needed for it.
    for (genvar g = 0; g < THREADS_PER_BLOCK; g++) begin : g_lane
        assign active[g]       = (int'(tc_q) > g);
        assign lane_busy[g]    = active[g] &&
                                 ((lsu_state[2*g +: 2] == LSU_REQUESTING) ||
                                  (lsu_state[2*g +: 2] == LSU_WAITING));
        assign lane_diverge[g] = active[g] && (next_pc[g*PW +: PW] != next_pc[PW-1:0]);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        div_d   = div_q;
        busy_d  = busy_q;
        tc_d    = tc_q;

        if ((state_q != CORE_IDLE) && (state_q != CORE_DONE) && (busy_q != '1)) begin
            busy_d = busy_q + CW'(1);
        end

        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    state_d = CORE_FETCH;
                    // Counts above the lane count would mark nonexistent lanes active.
                    tc_d    = (thread_count > TC_W'(THREADS_PER_BLOCK)) ?
                              TC_W'(THREADS_PER_BLOCK) : thread_count;
                end
            end
            CORE_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
            end
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                if (lane_busy == '0) state_d = CORE_EXECUTE;
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (decoded_ret) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CORE_FETCH;
                    pc_d    = next_pc[PW-1:0];
                    if (lane_diverge != '0) div_d = 1'b1;
                end
            end
            CORE_DONE: state_d = CORE_DONE;
            default:   state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CORE_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
            busy_q  <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
        end
    end

    assign core_state       = state_q;
    assign current_pc       = pc_q;
    assign done             = done_q;
    assign divergence_error = div_q;
    assign busy_cycles      = busy_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: instruction sequencing, memory wait, lane masking,
// divergence, RET/DONE and mid-flight reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_core_scheduler;

    localparam int T  = 4;
    localparam int PW = 8;
    localparam int CW = 16;

    localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                           S_REQUEST = 3'b011, S_WAIT = 3'b100, S_EXECUTE = 3'b101,
                           S_UPDATE = 3'b110, S_DONE = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    thread_count;
    logic [2:0]    fetcher_state;
    logic          decoded_ret;
    logic [2*T-1:0]  lsu_state;
    logic [PW*T-1:0] next_pc;
    logic [2:0]    core_state;
    logic [PW-1:0] current_pc;
    logic          done;
    logic          divergence_error;
    logic [CW-1:0] busy_cycles;

    int total = 0;
    int fails = 0;

    core_scheduler #(
        .THREADS_PER_BLOCK    (T),
        .PROGRAM_MEM_ADDR_BITS(PW),
        .CYCLE_COUNT_BITS     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .thread_count    (thread_count),
        .fetcher_state   (fetcher_state),
        .decoded_ret     (decoded_ret),
        .lsu_state       (lsu_state),
        .next_pc         (next_pc),
        .core_state      (core_state),
        .current_pc      (current_pc),
        .done            (done),
        .divergence_error(divergence_error),
        .busy_cycles     (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the first FETCH cycle; leaves just after the UPDATE edge.
    // Assumes LSU inputs keep WAIT to a single cycle.
    task automatic run_instr(input int fetch_cycles);
        for (int i = 0; i < fetch_cycles; i++) begin
            chk("fetch", core_state, S_FETCH);
            fetcher_state = (i == fetch_cycles - 1) ? 3'b010 : 3'b000;
            tick();
        end
        fetcher_state = 3'b000;
        chk("decode", core_state, S_DECODE);
        tick();
        chk("request", core_state, S_REQUEST);
        tick();
        chk("wait", core_state, S_WAIT);
        tick();
        chk("execute", core_state, S_EXECUTE);
        tick();
        chk("update", core_state, S_UPDATE);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_count = '0; fetcher_state = '0;
        decoded_ret = 1'b0; lsu_state = '0; next_pc = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", core_state, S_IDLE);
        chk("rst_pc", current_pc, 0);
        chk("rst_done", done, 0);
        chk("rst_div", divergence_error, 0);
        chk("rst_busy", busy_cycles, 0);

        // Basic instruction, 4 threads, 3-cycle fetch.
        thread_count = 3'd4;
        next_pc = {4{8'd1}};
        start = 1'b1; tick(); start = 1'b0;
        run_instr(3);
        chk("i1_state", core_state, S_FETCH);
        chk("i1_pc", current_pc, 1);
        chk("i1_busy", busy_cycles, 8);

        // Load on lane 2: REQUESTING during REQUEST, WAITING for 5 cycles, other lanes DONE.
        next_pc = {4{8'd2}};
        chk("ldr_fetch", core_state, S_FETCH);
        fetcher_state = 3'b010; tick(); fetcher_state = 3'b000;
        chk("ldr_decode", core_state, S_DECODE);
        lsu_state = 8'b11_11_11_11;
        tick();
        chk("ldr_request", core_state, S_REQUEST);
        lsu_state = 8'b11_01_11_11;
        tick();
        lsu_state = 8'b11_10_11_11;
        for (int i = 0; i < 5; i++) begin
            chk("ldr_wait", core_state, S_WAIT);
            tick();
        end
        lsu_state = 8'b11_11_11_11;
        chk("ldr_wait_last", core_state, S_WAIT);
        tick();
        chk("ldr_execute", core_state, S_EXECUTE);
        tick();
        chk("ldr_update", core_state, S_UPDATE);
        tick();
        chk("ldr_next", core_state, S_FETCH);
        chk("ldr_pc", current_pc, 2);
        chk("ldr_busy", busy_cycles, 19);
        chk("ldr_div", divergence_error, 0);
        lsu_state = '0;

        // Two active lanes; lane 3 stuck in WAITING and lanes 2/3 disagree on PC.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_state", core_state, S_IDLE);
        chk("rst2_pc", current_pc, 0);
        thread_count = 3'd2;
        lsu_state = 8'b10_00_00_00;
        next_pc = {8'd8, 8'd9, 8'd3, 8'd3};
        start = 1'b1; tick(); start = 1'b0;
        run_instr(1);
        chk("mask_pc", current_pc, 3);
        chk("mask_div", divergence_error, 0);

        // Active lanes disagree: lane0=5, lane1=7.
        next_pc = {8'd5, 8'd5, 8'd7, 8'd5};
        run_instr(1);
        chk("div_pc", current_pc, 5);
        chk("div_set", divergence_error, 1);
        next_pc = {4{8'd6}};
        run_instr(1);
        next_pc = {4{8'd7}};
        run_instr(1);
        next_pc = {4{8'd9}};
        run_instr(1);
        chk("div_pc9", current_pc, 9);
        chk("div_sticky", divergence_error, 1);

        // RET at pc 9.
        decoded_ret = 1'b1;
        next_pc = {4{8'h44}};
        run_instr(1);
        chk("ret_state", core_state, S_DONE);
        chk("ret_done", done, 1);
        chk("ret_pc", current_pc, 9);
        chk("ret_busy", busy_cycles, 36);
        chk("ret_div", divergence_error, 1);
        start = 1'b1; tick(); tick(); start = 1'b0; tick();
        chk("done_hold", core_state, S_DONE);
        chk("done_flag", done, 1);
        chk("done_busy", busy_cycles, 36);
        decoded_ret = 1'b0;

        // Reset while stalled in WAIT, with start asserted alongside it.
        reset = 1'b1; tick(); reset = 1'b0;
        thread_count = 3'd4;
        lsu_state = 8'b00_00_00_01;
        next_pc = {4{8'h22}};
        start = 1'b1; tick(); start = 1'b0;
        fetcher_state = 3'b010; tick(); fetcher_state = 3'b000;
        tick(); tick();
        chk("busy_wait1", core_state, S_WAIT);
        tick();
        chk("busy_wait2", core_state, S_WAIT);
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        chk("mid_rst_state", core_state, S_IDLE);
        chk("mid_rst_pc", current_pc, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy_cycles, 0);
        chk("mid_rst_div", divergence_error, 0);
        tick();
        chk("rst_wins", core_state, S_IDLE);

        // Fresh start, oversize thread count clamped.
        lsu_state = '0;
        thread_count = 3'd7;
        start = 1'b1; tick(); start = 1'b0;
        run_instr(2);
        chk("fresh_state", core_state, S_FETCH);
        chk("fresh_pc", current_pc, 8'h22);
        chk("fresh_busy", busy_cycles, 7);
        chk("fresh_div", divergence_error, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM that sequences every instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
- Broadcasts core_state to the fetcher, the decoder, the LSUs, the ALUs and the PC units.
- Waits on memory traffic from active threads only, owns the core's current PC, and raises done on RET.
- Sits directly upstream of the decoder; the decoder latches the instruction while core_state == DECODE (3'b010).

Parameters:
- THREADS_PER_BLOCK, 4: number of thread lanes in the core.
- PROGRAM_MEM_ADDR_BITS, 8: width of a PC.
- CYCLE_COUNT_BITS, 16: width of the busy-cycle counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin executing the block; sampled only in IDLE.
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads; latched at start.
- fetcher_state  in  3  fetcher FSM state; FETCHED = 3'b010.
- decoded_ret  in  1  decoder output: current instruction is RET.
- lsu_state  in  2*THREADS_PER_BLOCK  per-thread LSU state, packed, lane i at [2i+1:2i]. Encoding: IDLE 00, REQUESTING 01, WAITING 10, DONE 11.
- next_pc  in  PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK  per-thread PC-unit result, packed.
- core_state  out  3  current scheduler state.
- current_pc  out  PROGRAM_MEM_ADDR_BITS  PC of the instruction being executed.
- done  out  1  block finished.
- divergence_error  out  1  sticky flag: active threads disagreed on next PC.
- busy_cycles  out  CYCLE_COUNT_BITS  cycles spent outside IDLE and DONE.

Behaviour:
- State encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Reset values: core_state=IDLE, current_pc=0, done=0, divergence_error=0, busy_cycles=0, latched thread count=0.
- All outputs are registered.
- Transitions:
  - IDLE: start=1 → FETCH, latch thread_count. Otherwise hold.
  - FETCH: fetcher_state==FETCHED → DECODE. Otherwise hold, with no timeout.
  - DECODE: unconditionally → REQUEST after 1 cycle.
  - REQUEST: unconditionally → WAIT after 1 cycle. LSUs sample REQUEST on this edge.
  - WAIT: hold while any active lane i (i < latched count) has lsu_state REQUESTING or WAITING. Otherwise → EXECUTE.
    - Inactive lanes are ignored.
    - Lanes in IDLE or DONE count as not busy, so non-memory instructions spend exactly 1 cycle in WAIT.
  - EXECUTE: unconditionally → UPDATE after 1 cycle.
  - UPDATE, decoded_ret=1: → DONE, done<=1, current_pc unchanged.
  - UPDATE, decoded_ret=0: current_pc<=next_pc lane 0, → FETCH. If any other active lane's next_pc differs from lane 0, divergence_error<=1.
  - DONE: hold. done stays 1 and start is ignored until reset.
- Minimum instruction latency: 6 cycles plus the fetch wait plus memory wait cycles.
- thread_count==0:
  - No lane is active, so WAIT always exits after 1 cycle.
  - PC still comes from lane 0.
  - The divergence check is vacuous.
- thread_count > THREADS_PER_BLOCK is clamped to THREADS_PER_BLOCK.
- busy_cycles increments in states 001–110 and saturates at all-ones.
- divergence_error is cleared only by reset.
- current_pc wraps modulo 2^PROGRAM_MEM_ADDR_BITS. No check is made, because the value comes from next_pc as given.
- Reset mid-operation (any state): next cycle core_state=IDLE and every output holds its reset value. The latched thread count is cleared.
- start asserted on the same cycle as reset: reset wins.

Decomposition:
- Shared package gpu_core_pkg holds:
  - core-state localparams (IDLE…DONE);
  - LSU state encodings;
  - the fetcher FETCHED encoding.
- The decoder, fetcher and LSU use the same package.
- No sub-module. The active-lane mask and the busy/divergence reductions are inline generate loops.

Test Plan:
- Reset, start with thread_count=4; fetcher reaches FETCHED 3 cycles after FETCH; all LSUs IDLE; next_pc all 1; decoded_ret=0.
  → State sequence 001×3, 010, 011, 100, 101, 110, 001. current_pc goes 0→1 at UPDATE exit. busy_cycles=8 at the second FETCH.
- LDR: lane 2 lsu_state REQUESTING 1 cycle, then WAITING 5 cycles, then DONE.
  → WAIT lasts exactly 6 cycles, then EXECUTE. Other lanes DONE do not shorten it.
- thread_count=2, lane 3 lsu_state stuck WAITING.
  → WAIT exits after 1 cycle. The lane-3 next_pc mismatch does not set divergence_error.
- thread_count=2, next_pc lane0=5, lane1=7.
  → current_pc=5 and divergence_error=1, still 1 after three further instructions.
- decoded_ret=1 at UPDATE with current_pc=9.
  → core_state=111, done=1, current_pc stays 9. start pulses are ignored and busy_cycles frozen.
- reset asserted for 1 cycle while in WAIT with LSUs busy.
  → Next cycle: core_state=000, current_pc=0, done=0, busy_cycles=0. A fresh start executes normally.
